// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared memory-engine types and wormhole header helpers
package bp_me_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_half_block_cfg
    } bp_params_e;

    typedef enum logic {
        e_ready,
        e_send
    } bp_me_flit_tx_state_e;

    function automatic int bp_cce_block_width(bp_params_e cfg);
        case (cfg)
            e_bp_half_block_cfg: return 256;
            default:             return 512;
        endcase
    endfunction

    function automatic int bp_cce_mem_msg_header_width(bp_params_e cfg);
        case (cfg)
            e_bp_half_block_cfg: return 120;
            default:             return 120;
        endcase
    endfunction

    // Header layout is {msg_hdr, cid, len, cord}, padded up to whole flits.
    function automatic int bp_mem_wormhole_header_width(int flit_width, int cord_width,
                                                        int len_width, int cid_width,
                                                        int msg_hdr_width);
        int raw;
        raw = cord_width + len_width + cid_width + msg_hdr_width;
        return ((raw + flit_width - 1) / flit_width) * flit_width;
    endfunction

    // The len field sits directly above the cord field.
    function automatic int bp_mem_wormhole_len_offset(int cord_width);
        return cord_width;
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// rtl/bsg_counter_clear_up.sv - up counter with synchronous clear and async reset
module bsg_counter_clear_up
    #(parameter int max_val_p = 1,
      parameter int init_val_p = 0,
      localparam int ptr_width_lp = (max_val_p > 0) ? $clog2(max_val_p + 1) : 1)
    (input  logic                    clk_i,
     input  logic                    reset_i,
     input  logic                    clear_i,
     input  logic                    up_i,
     output logic [ptr_width_lp-1:0] count_o);

    logic [ptr_width_lp-1:0] count_q, count_d;

    // Clear and up in the same cycle restart the count at one.
    always_comb begin
        count_d = clear_i ? '0 : count_q;
        count_d = count_d + ptr_width_lp'(up_i);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= ptr_width_lp'(init_val_p);
        end else if (clear_i || up_i) begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bp_me_wormhole_mem_cmd_flit_tx.sv
// rtl/bp_me_wormhole_mem_cmd_flit_tx.sv - serialises a header+payload command into link flits
module bp_me_wormhole_mem_cmd_flit_tx
    import bp_me_pkg::*;
    #(parameter bp_params_e bp_params_p = e_bp_default_cfg,
      parameter int flit_width_p = 64,
      parameter int cord_width_p = 7,
      parameter int len_width_p  = 4,
      parameter int cid_width_p  = 2,
      localparam int cce_block_width_p = bp_cce_block_width(bp_params_p),
      localparam int cce_mem_msg_header_width_lp = bp_cce_mem_msg_header_width(bp_params_p),
      localparam int wh_hdr_width_lp = bp_mem_wormhole_header_width(flit_width_p, cord_width_p,
                                           len_width_p, cid_width_p, cce_mem_msg_header_width_lp),
      localparam int max_flits_lp = (wh_hdr_width_lp + cce_block_width_p + flit_width_p - 1) / flit_width_p)
    (input  logic                         clk_i,
     input  logic                         reset_i,
     input  logic [wh_hdr_width_lp-1:0]   wh_header_i,
     input  logic [cce_block_width_p-1:0] data_i,
     input  logic                         v_i,
     output logic                         ready_and_o,
     output logic [flit_width_p-1:0]      link_data_o,
     output logic                         link_v_o,
     input  logic                         link_ready_and_i,
     output logic                         len_err_o);

    localparam int max_len_lp   = max_flits_lp - 1;
    localparam int cnt_width_lp = (max_len_lp > 0) ? $clog2(max_len_lp + 1) : 1;
    localparam int pkt_width_lp = max_flits_lp * flit_width_p;
    localparam int len_lsb_lp   = bp_mem_wormhole_len_offset(cord_width_p);

    bp_me_flit_tx_state_e state_q;
    logic                                      len_err_q;
    logic [max_flits_lp-1:0][flit_width_p-1:0] packet_q;
    logic [cnt_width_lp-1:0]                   len_q, len_d, cnt;
    logic [len_width_p-1:0]                    len_raw;
    logic                                      len_over, accept, flit_hs, last_flit;

    assign len_raw  = wh_header_i[len_lsb_lp +: len_width_p];
    assign len_over = 32'(len_raw) > 32'(max_len_lp);
    assign len_d    = len_over ? cnt_width_lp'(max_len_lp) : cnt_width_lp'(len_raw);

    // Gating with reset_i keeps ready low for the whole reset window, not just after an edge.
    assign ready_and_o = (state_q == e_ready) && !reset_i;
    assign link_v_o    = (state_q == e_send);
    assign accept      = v_i && ready_and_o;
    assign flit_hs     = link_v_o && link_ready_and_i;
    assign last_flit   = flit_hs && (cnt == len_q);
    assign link_data_o = packet_q[cnt];
    assign len_err_o   = len_err_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= e_ready;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= accept && len_over;
            case (state_q)
                e_ready: if (accept)    state_q <= e_send;
                e_send:  if (last_flit) state_q <= e_ready;
                default:                state_q <= e_ready;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            packet_q <= pkt_width_lp'({data_i, wh_header_i});
            len_q    <= len_d;
        end
    end

    bsg_counter_clear_up #(
        .max_val_p (max_len_lp),
        .init_val_p(0)
    ) flit_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(accept),
        .up_i   (flit_hs && !last_flit),
        .count_o(cnt)
    );

endmodule

// File: tb/tb_bp_me_wormhole_mem_cmd_flit_tx.sv
// tb/tb_bp_me_wormhole_mem_cmd_flit_tx.sv - directed bench for the command flit serialiser
module tb_bp_me_wormhole_mem_cmd_flit_tx;
    import bp_me_pkg::*;

    localparam int FW = 64, CORD = 7, LENW = 4, CID = 2;
    localparam int HW = 192, BW = 512, MAXF = 11, PW = MAXF * FW;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [HW-1:0] wh_header_i = '0;
    logic [BW-1:0] data_i = '0;
    logic          v_i = 1'b0;
    logic          ready_and_o;
    logic [FW-1:0] link_data_o;
    logic          link_v_o;
    logic          link_ready_and_i = 1'b0;
    logic          len_err_o;

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] captured [MAXF];

    bp_me_wormhole_mem_cmd_flit_tx #(
        .bp_params_p (e_bp_default_cfg),
        .flit_width_p(FW),
        .cord_width_p(CORD),
        .len_width_p (LENW),
        .cid_width_p (CID)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .wh_header_i     (wh_header_i),
        .data_i          (data_i),
        .v_i             (v_i),
        .ready_and_o     (ready_and_o),
        .link_data_o     (link_data_o),
        .link_v_o        (link_v_o),
        .link_ready_and_i(link_ready_and_i),
        .len_err_o       (len_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  len;
        logic [7:0]  seed;
        logic [31:0] rdy_mask;
        int          exp_flits;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [HW-1:0] make_hdr(input logic [3:0] len, input logic [7:0] seed);
        logic [HW-1:0] h;
        for (int w = 0; w < HW / FW; w++)
            h[w*FW +: FW] = {16'hC0DE, 8'(w), seed, 32'h1234_5678 + 32'(w)};
        h[CORD +: LENW] = len;
        return h;
    endfunction

    function automatic logic [BW-1:0] make_data(input logic [7:0] seed);
        logic [BW-1:0] d;
        for (int i = 0; i < BW / 8; i++)
            d[i*8 +: 8] = 8'(i) ^ seed;
        return d;
    endfunction

    task automatic send_pkt(input string name, input logic [3:0] len, input logic [7:0] seed,
                            input logic [31:0] mask, input int exp_flits, input logic exp_err);
        logic [HW-1:0] hdr;
        logic [BW-1:0] data;
        logic [PW-1:0] pkt;
        logic          rdy;
        int            idx;
        int            step;
        hdr  = make_hdr(len, seed);
        data = make_data(seed);
        pkt  = {data, hdr};
        idx  = 0;
        step = 0;
        @(negedge clk);
        check({name, " ready_before"}, 64'(ready_and_o), 64'd1);
        v_i = 1'b1;
        wh_header_i = hdr;
        data_i = data;
        @(negedge clk);
        v_i = 1'b0;
        check({name, " len_err"}, 64'(len_err_o), 64'(exp_err));
        while (idx < exp_flits && step < 200) begin
            check($sformatf("%s v[%0d]", name, idx), 64'(link_v_o), 64'd1);
            check($sformatf("%s flit[%0d]", name, idx), link_data_o, pkt[idx*FW +: FW]);
            if (step == 1)
                check({name, " len_err_once"}, 64'(len_err_o), 64'd0);
            rdy = (step < 32) ? mask[step] : 1'b1;
            link_ready_and_i = rdy;
            if (rdy) captured[idx] = link_data_o;
            @(negedge clk);
            if (rdy) idx++;
            step++;
        end
        link_ready_and_i = 1'b0;
        check({name, " flit_count"}, 64'(idx), 64'(exp_flits));
        check({name, " v_after"}, 64'(link_v_o), 64'd0);
        check({name, " ready_after"}, 64'(ready_and_o), 64'd1);
    endtask

    vec_t vecs [6];

    initial begin
        logic [HW-1:0] ha, hb;
        logic [BW-1:0] da, db;
        logic [PW-1:0] pa, pb;
        logic          exp_v [6];

        vecs[0] = '{"read_len2",   4'd2,  8'h00, 32'hFFFF_FFFF, 3,  1'b0};
        vecs[1] = '{"stall_len2",  4'd2,  8'h3C, 32'hFFFF_FFF9, 3,  1'b0};
        vecs[2] = '{"over_len15",  4'd15, 8'h5A, 32'hFFFF_FFFF, 11, 1'b1};
        vecs[3] = '{"len0",        4'd0,  8'h77, 32'hFFFF_FFFF, 1,  1'b0};
        vecs[4] = '{"alt_len10",   4'd10, 8'h81, 32'h5555_5555, 11, 1'b0};
        vecs[5] = '{"edge_len11",  4'd11, 8'h09, 32'hFFFF_FFFF, 11, 1'b1};

        // reset state
        @(negedge clk);
        check("rst ready", 64'(ready_and_o), 64'd0);
        check("rst link_v", 64'(link_v_o), 64'd0);
        check("rst len_err", 64'(len_err_o), 64'd0);
        reset_i = 1'b0;
        #1;
        check("post_rst ready", 64'(ready_and_o), 64'd1);

        for (int i = 0; i < 6; i++)
            send_pkt(vecs[i].name, vecs[i].len, vecs[i].seed, vecs[i].rdy_mask,
                     vecs[i].exp_flits, vecs[i].exp_err);

        // full 64B write with byte-index payload
        send_pkt("write_len10", 4'd10, 8'h00, 32'hFFFF_FFFF, 11, 1'b0);
        check("write flit3", captured[3], 64'h0706_0504_0302_0100);
        check("write flit10", captured[10], 64'h3F3E_3D3C_3B3A_3938);

        // back-to-back packets with v_i held high
        ha = make_hdr(4'd1, 8'h11); da = make_data(8'h11); pa = {da, ha};
        hb = make_hdr(4'd1, 8'h22); db = make_data(8'h22); pb = {db, hb};
        exp_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        v_i = 1'b1; wh_header_i = ha; data_i = da; link_ready_and_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("b2b v[%0d]", k), 64'(link_v_o), 64'(exp_v[k]));
            if (k == 0) begin
                check("b2b busy_ready", 64'(ready_and_o), 64'd0);
                check("b2b A0", link_data_o, pa[0 +: FW]);
                wh_header_i = hb; data_i = db;
            end
            if (k == 1) check("b2b A1", link_data_o, pa[FW +: FW]);
            if (k == 2) check("b2b bubble_ready", 64'(ready_and_o), 64'd1);
            if (k == 3) begin
                check("b2b B0", link_data_o, pb[0 +: FW]);
                v_i = 1'b0;
            end
            if (k == 4) check("b2b B1", link_data_o, pb[FW +: FW]);
        end
        link_ready_and_i = 1'b0;

        // reset after two flits of a len=10 packet
        ha = make_hdr(4'd10, 8'h44); da = make_data(8'h44); pa = {da, ha};
        @(negedge clk);
        v_i = 1'b1; wh_header_i = ha; data_i = da;
        @(negedge clk);
        v_i = 1'b0; link_ready_and_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid flit2", link_data_o, pa[2*FW +: FW]);
        #2 reset_i = 1'b1;
        #1;
        check("mid_rst link_v", 64'(link_v_o), 64'd0);
        check("mid_rst ready", 64'(ready_and_o), 64'd0);
        check("mid_rst len_err", 64'(len_err_o), 64'd0);
        @(negedge clk);
        reset_i = 1'b0;
        link_ready_and_i = 1'b0;
        #1;
        check("mid_post link_v", 64'(link_v_o), 64'd0);
        check("mid_post ready", 64'(ready_and_o), 64'd1);
        send_pkt("after_rst", 4'd2, 8'h66, 32'hFFFF_FFFF, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
